regfile_wb_stage: RTL and testbench

//  Write-back stage feeding the 32 x 64 register file: registers one write-back request
//  (valid, reg_write, Rd, data) per cycle and drives the one-hot write enables and

---
 rtl/regfile_wb_stage.sv | 84 ++++++++
 tb/tb_regfile_wb_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_stage.sv
// Write-back stage for the 32 x 64 register file: one registered request per cycle,
// one-hot write enables, read-port bypass and a saturating retired-write count.
module regfile_wb_stage #(
  parameter  int WIDTH    = 64,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 31,
  parameter  int CNT_W    = 16,
  localparam int RD_W     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic             wb_reg_write,
  input  logic [RD_W-1:0]  wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [NREGS-1:0] write_en,
  output logic [WIDTH-1:0] write_data,
  input  logic [RD_W-1:0]  byp_rd1,
  input  logic [RD_W-1:0]  byp_rd2,
  output logic             byp_hit1,
  output logic             byp_hit2,
  output logic [WIDTH-1:0] byp_data,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [RD_W-1:0] ZERO_IDX = RD_W'(ZERO_REG);

  logic             vld_p1;
  logic             rw_p1;
  logic [RD_W-1:0]  rd_p1;
  logic [WIDTH-1:0] data_p1;
  logic             fired_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             pend_p1;
  logic             fire_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Stage p1: captured write-back request; a held entry writes only once.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rw_p1    <= 1'b0;
      rd_p1    <= '0;
      data_p1  <= '0;
      fired_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      if (flush) begin
        vld_p1   <= 1'b0;
        fired_p1 <= 1'b0;
      end else if (stall) begin
        if (fire_p1) fired_p1 <= 1'b1;
      end else begin
        vld_p1   <= wb_valid;
        rw_p1    <= wb_reg_write;
        rd_p1    <= wb_rd;
        data_p1  <= wb_data;
        fired_p1 <= 1'b0;
      end
      if (fire_p1) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign pend_p1 = vld_p1 & rw_p1 & (rd_p1 != ZERO_IDX);
  assign fire_p1 = pend_p1 & ~fired_p1;

  always_comb begin
    write_en = '0;
    if (fire_p1) write_en[rd_p1] = 1'b1;
  end

  // Bypass reports the pending value even after it was written, until replaced.
  assign byp_hit1    = pend_p1 & (rd_p1 == byp_rd1);
  assign byp_hit2    = pend_p1 & (rd_p1 == byp_rd2);
  assign byp_data    = data_p1;
  assign write_data  = data_p1;
  assign retired_cnt = cnt_p1;

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Bench for regfile_wb_stage: directed scenarios plus randomized traffic against a
// request-level reference model of the write-back stage.
module tb_regfile_wb_stage;

  localparam int WIDTH = 64;
  localparam int NREGS = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, stall, flush;
  logic             wb_valid, wb_reg_write;
  logic [4:0]       wb_rd, byp_rd1, byp_rd2;
  logic [WIDTH-1:0] wb_data;
  logic [NREGS-1:0] write_en;
  logic [WIDTH-1:0] write_data, byp_data;
  logic             byp_hit1, byp_hit2;
  logic [CNT_W-1:0] retired_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model: the request currently owning the stage
  bit          m_valid, m_rw, m_done;
  int          m_rd;
  logic [63:0] m_data;
  int          m_cnt;

  regfile_wb_stage #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_REG(31), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .write_en(write_en), .write_data(write_data),
    .byp_rd1(byp_rd1), .byp_rd2(byp_rd2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data(byp_data), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // register index the held request still has to write, or -1
  function automatic int target();
    if (m_valid && m_rw && m_rd != 31 && !m_done) return m_rd;
    return -1;
  endfunction

  function automatic bit hit(input int idx);
    return m_valid && m_rw && m_rd != 31 && m_rd == idx;
  endfunction

  task automatic check_all(input string tag);
    int t;
    logic [31:0] we;
    t  = target();
    we = (t >= 0) ? (32'd1 << t) : 32'd0;
    chk({tag, ".we"},   write_en, we);
    chk({tag, ".wd"},   write_data, m_data);
    chk({tag, ".hit1"}, byp_hit1, hit(int'(byp_rd1)));
    chk({tag, ".hit2"}, byp_hit2, hit(int'(byp_rd2)));
    chk({tag, ".bd"},   byp_data, m_data);
    chk({tag, ".cnt"},  retired_cnt, m_cnt);
  endtask

  // what one rising edge does to the stage, given the inputs present before it
  task automatic model_edge();
    bool_upd();
  endtask

  task automatic bool_upd();
    int t;
    t = target();
    if (reset) begin
      m_valid = 0; m_rw = 0; m_done = 0; m_rd = 0; m_data = '0; m_cnt = 0;
    end else begin
      if (t >= 0 && m_cnt < CNT_MAX) m_cnt++;
      if (flush) begin
        m_valid = 0; m_done = 0;
      end else if (stall) begin
        if (t >= 0) m_done = 1;
      end else begin
        m_valid = wb_valid; m_rw = wb_reg_write; m_rd = int'(wb_rd);
        m_data = wb_data; m_done = 0;
      end
    end
  endtask

  // check the settled outputs, then advance one clock
  task automatic tick(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [63:0] d);
    wb_valid = v; wb_reg_write = rw; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; byp_rd1 = 0; byp_rd2 = 0;
    drive(0, 0, 0, '0);
    m_valid = 0; m_rw = 0; m_done = 0; m_rd = 0; m_data = '0; m_cnt = 0;
    @(posedge clk); model_edge(); #1;
    tick("reset");
    reset = 0;
    #1;
    chk("reset.we", write_en, 32'h0);
    chk("reset.cnt", retired_cnt, 0);

    // 1: basic write to r5
    drive(1, 1, 5, 64'hDEAD_BEEF);
    tick("t1.req");
    drive(0, 0, 0, '0);
    #1;
    chk("t1.we_const", write_en, 32'h0000_0020);
    chk("t1.wd_const", write_data, 64'hDEAD_BEEF);
    tick("t1.wr");
    #1;
    chk("t1.cnt_const", retired_cnt, 1);

    // 2: zero register is never written nor bypassed
    byp_rd1 = 31;
    drive(1, 1, 31, 64'h1234);
    tick("t2.req");
    drive(0, 0, 0, '0);
    #1;
    chk("t2.we_const", write_en, 32'h0);
    chk("t2.hit_const", byp_hit1, 1'b0);
    tick("t2.hold");
    chk("t2.cnt_const", retired_cnt, 1);

    // 3: stall holds the entry; it writes exactly once
    drive(1, 1, 7, 64'h7777_0000_7777);
    tick("t3.req");
    stall = 1;
    drive(1, 1, 9, 64'h9999);
    #1;
    chk("t3.we_first", write_en, 32'h80);
    tick("t3.s1");
    chk("t3.we_held", write_en, 32'h0);
    tick("t3.s2");
    tick("t3.s3");
    chk("t3.bd_held", byp_data, 64'h7777_0000_7777);
    chk("t3.cnt_const", retired_cnt, 2);
    stall = 0;
    drive(0, 0, 0, '0);
    tick("t3.end");

    // 4: flush beats stall; the visible write still happens that cycle
    byp_rd1 = 3;
    drive(1, 1, 3, 64'h3333);
    tick("t4.req");
    flush = 1; stall = 1;
    drive(0, 0, 0, '0);
    #1;
    chk("t4.we_const", write_en, 32'h8);
    chk("t4.hit_const", byp_hit1, 1'b1);
    tick("t4.flush");
    flush = 0; stall = 0;
    #1;
    chk("t4.we_after", write_en, 32'h0);
    chk("t4.hit_after", byp_hit1, 1'b0);
    tick("t4.end");

    // 5: back-to-back writes with bypass on the middle one
    byp_rd1 = 2;
    drive(1, 1, 1, 64'hA1);
    tick("t5.r1");
    drive(1, 1, 2, 64'hB2);
    tick("t5.r2");
    drive(1, 1, 3, 64'hC3);
    #1;
    chk("t5.we_mid", write_en, 32'h4);
    chk("t5.hit_mid", byp_hit1, 1'b1);
    chk("t5.bd_mid", byp_data, 64'hB2);
    tick("t5.r3");
    drive(0, 0, 0, '0);
    #1;
    chk("t5.hit_last", byp_hit1, 1'b0);
    tick("t5.end");

    // 6: counter saturation, then reset clears it
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 5'(i % 31), 64'(i));
      tick("t6.wr");
    end
    drive(0, 0, 0, '0);
    tick("t6.idle");
    chk("t6.sat", retired_cnt, CNT_MAX);
    reset = 1;
    tick("t6.rst");
    reset = 0;
    chk("t6.cleared", retired_cnt, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(99) < 2);
      stall = ($urandom_range(99) < 30);
      flush = ($urandom_range(99) < 10);
      wb_valid = ($urandom_range(99) < 80);
      wb_reg_write = ($urandom_range(99) < 85);
      wb_rd = ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(31));
      wb_data = {$urandom, $urandom};
      byp_rd1 = ($urandom_range(1) == 0) ? wb_rd : 5'($urandom_range(31));
      byp_rd2 = 5'(m_rd);
      tick("rand");
    end
    reset = 0; stall = 0; flush = 0;
    drive(0, 0, 0, '0);
    tick("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
